// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg: shared FSM encoding and 50 MHz board timing constants for the key conditioner.
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int BOARD_DEBOUNCE_CYCLES = 500_000;
    localparam int BOARD_REPEAT_CYCLES   = 25_000_000;

    function automatic int count_width(input int debounce, input int rpt);
        return $clog2((debounce > rpt ? debounce : rpt) + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// key_conditioner_channel: one key -- synchronizer, debounce FSM, repeat timer, registered pulses.
module key_conditioner_channel
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = BOARD_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CW = count_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES == 0 ? 0 : REPEAT_CYCLES - 1);
    localparam bit RP_ON = REPEAT_CYCLES != 0;

    logic [1:0] sync;
    key_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, rcnt, rcnt_nxt;
    logic held_nxt, rep_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync          <= '0;
            state         <= RELEASED;
            cnt           <= '0;
            rcnt          <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync          <= {sync[0], ~key};
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            rcnt          <= rcnt_nxt;
            pressed       <= held_nxt;
            press_pulse   <= held_nxt & ~pressed;
            release_pulse <= ~held_nxt & pressed;
            repeat_pulse  <= rep_nxt;
        end
    end

    // Repeat timer advances only in PRESSED, so it freezes while a release is being qualified.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rcnt_nxt  = rcnt;
        rep_nxt   = 1'b0;
        case (state)
            RELEASED:
                if (sync[1]) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            PRESS_WAIT:
                if (!sync[1]) state_nxt = RELEASED;
                else if (cnt == DB_LAST) begin
                    state_nxt = PRESSED;
                    rcnt_nxt  = '0;
                end else cnt_nxt = cnt + 1'b1;
            PRESSED: begin
                if (!sync[1]) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
                if (RP_ON) begin
                    rep_nxt  = rcnt == RP_LAST;
                    rcnt_nxt = rep_nxt ? '0 : rcnt + 1'b1;
                end
            end
            RELEASE_WAIT:
                if (sync[1]) state_nxt = PRESSED;
                else if (cnt == DB_LAST) state_nxt = RELEASED;
                else cnt_nxt = cnt + 1'b1;
            default: state_nxt = RELEASED;
        endcase
        held_nxt = state_nxt == PRESSED || state_nxt == RELEASE_WAIT;
    end

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: W independent push-button channels, active-low raw keys to clean levels and pulses.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int W               = 2,
    parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = BOARD_REPEAT_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] key,
    output logic [W-1:0] pressed,
    output logic [W-1:0] press_pulse,
    output logic [W-1:0] release_pulse,
    output logic [W-1:0] repeat_pulse
);

    for (genvar i = 0; i < W; i++) begin : g_ch
        key_conditioner_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .key          (key[i]),
            .pressed      (pressed[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench; one DUT with repeat enabled, one with repeat disabled, shared keys.
module tb_key_conditioner;

    localparam int D = 4;
    localparam int R = 8;

    typedef struct {
        int          cyc;
        logic [15:0] v;
    } exp_t;

    logic clk, reset;
    logic [1:0] key;
    logic [1:0] pressed, press_pulse, release_pulse, repeat_pulse;
    logic [1:0] pressed0, press_pulse0, release_pulse0, repeat_pulse0;
    logic [15:0] got;
    int cyc, n_vec, n_err;
    exp_t q[$];

    key_conditioner #(.W(2), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .reset(reset), .key(key), .pressed(pressed), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
    );

    key_conditioner #(.W(2), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .key(key), .pressed(pressed0), .press_pulse(press_pulse0),
        .release_pulse(release_pulse0), .repeat_pulse(repeat_pulse0)
    );

    assign got = {repeat_pulse0, release_pulse0, press_pulse0, pressed0,
                  repeat_pulse, release_pulse, press_pulse, pressed};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected {repeat, release, press, pressed} for a key pressed at negedge c0 and released at c0+h.
    function automatic logic [3:0] exp_key(input int i, input int c0, input int h, input bit rep_on);
        int p, r;
        logic prs, rep;
        p   = c0 + D + 3;
        r   = c0 + h + D + 3;
        prs = i >= p && i < r;
        rep = rep_on && i > p && (i - p) % R == 0 && i <= c0 + h + 3;
        return {rep, i == r, i == p, prs};
    endfunction

    function automatic logic [15:0] pack(input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] z0, input logic [3:0] z1);
        return {z1[3], z0[3], z1[2], z0[2], z1[1], z0[1], z1[0], z0[0],
                a1[3], a0[3], a1[2], a0[2], a1[1], a0[1], a1[0], a0[0]};
    endfunction

    // h0/h1 = 0 means that key stays released for the whole window.
    task automatic push_window(input int c0, input int n, input int h0, input int h1);
        logic [3:0] a0, a1, z0, z1;
        for (int i = c0 + 1; i <= c0 + n; i++) begin
            a0 = h0 > 0 ? exp_key(i, c0, h0, 1'b1) : 4'b0;
            a1 = h1 > 0 ? exp_key(i, c0, h1, 1'b1) : 4'b0;
            z0 = h0 > 0 ? exp_key(i, c0, h0, 1'b0) : 4'b0;
            z1 = h1 > 0 ? exp_key(i, c0, h1, 1'b0) : 4'b0;
            q.push_back('{cyc: i, v: pack(a0, a1, z0, z1)});
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            check("stale", 16'(q[0].cyc), 16'(cyc));
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) check($sformatf("cyc%0d", cyc), got, q.pop_front().v);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        key   = 2'b11;
        repeat (2) @(negedge clk);
        check("reset_state", got, 16'h0);
        key = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_hold", got, 16'h0);
        key   = 2'b11;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        c0 = cyc;
        key = 2'b10;
        push_window(c0, 42, 30, 0);
        wait_to(c0 + 30); key = 2'b11;
        wait_to(c0 + 42);

        c0 = cyc;
        key = 2'b10;
        push_window(c0, 20, 0, 0);
        wait_to(c0 + 3); key = 2'b11;
        wait_to(c0 + 4); key = 2'b10;
        wait_to(c0 + 7); key = 2'b11;
        wait_to(c0 + 20);

        c0 = cyc;
        key = 2'b00;
        push_window(c0, 47, 35, 18);
        wait_to(c0 + 18); key = 2'b10;
        wait_to(c0 + 35); key = 2'b11;
        wait_to(c0 + 47);

        c0 = cyc;
        key = 2'b01;
        push_window(c0, 52, 0, 40);
        wait_to(c0 + 40); key = 2'b11;
        wait_to(c0 + 52);

        c0 = cyc;
        key = 2'b10;
        push_window(c0, 6, 0, 0);
        push_window(c0 + 6, 32, 20, 0);
        wait_to(c0 + 4);
        #2 reset = 1'b1;
        #1 check("reset_wait", got, 16'h0);
        wait_to(c0 + 6); reset = 1'b0;
        wait_to(c0 + 26); key = 2'b11;
        wait_to(c0 + 38);

        c0 = cyc;
        key = 2'b01;
        push_window(c0, 10, 0, 1000);
        push_window(c0 + 10, 2, 0, 0);
        push_window(c0 + 12, 30, 0, 18);
        wait_to(c0 + 10);
        check("held_before_reset", {14'h0, pressed}, 16'h0002);
        #2 reset = 1'b1;
        #1 check("reset_async", got, 16'h0);
        wait_to(c0 + 12); reset = 1'b0;
        wait_to(c0 + 30); key = 2'b11;
        wait_to(c0 + 42);

        wait_to(cyc + 3);
        check("drain", 16'(q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
